// File: rtl/alarm_pkg.sv
// alarm_pkg: shared widths, moduli and the editor state encoding for multi_alarm_set.
package alarm_pkg;

  localparam int HOUR_W  = 5;
  localparam int MIN_W   = 6;
  localparam int MIN_MOD = 60;

  // The state value is driven straight onto o_field so the display can blink the active field.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEL     = 3'd1,
    ST_HOURS   = 3'd2,
    ST_MINUTES = 3'd3,
    ST_ENABLE  = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/mod_updown.sv
// mod_updown: combinational modulo-N +1/-1 step. inc and dec together leave the value unchanged.
module mod_updown #(
  parameter int N = 60,
  parameter int W = 6
) (
  input  logic [W-1:0] val_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] val_o
);

  // Wrap N-1 -> 0 going up and 0 -> N-1 going down.
  always_comb begin
    val_o = val_i;
    if (inc_i && !dec_i) begin
      val_o = (val_i == W'(N - 1)) ? '0 : val_i + 1'b1;
    end else if (dec_i && !inc_i) begin
      val_o = (val_i == '0) ? W'(N - 1) : val_i - 1'b1;
    end
  end

endmodule

// File: rtl/multi_alarm_set.sv
// multi_alarm_set: alarm-bank editor (shared mode/inc/dec buttons) and per-slot time matcher.
// Optional feature macro: ALARM_SNOOZE_EN adds snooze_button and a single pending-snooze target.
// Handshake: buttons are single-cycle pulses sampled on every rising clk edge; there is no
// ready/back-pressure, an edit is taken only while set_alarm_en is high, and mode beats inc/dec.
module multi_alarm_set
  import alarm_pkg::*;
#(
  parameter int  NUM_ALARMS = 4,
  parameter int  HOUR_MOD   = 24,
  parameter int  SNOOZE_MIN = 5,
  localparam int IDX_W      = $clog2(NUM_ALARMS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         set_alarm_en,
  input  logic                         mode_button,
  input  logic                         inc_button,
  input  logic                         dec_button,
  input  logic                         stop_button,
`ifdef ALARM_SNOOZE_EN
  input  logic                         snooze_button,
`endif
  input  logic [HOUR_W-1:0]            cur_hours,
  input  logic [MIN_W-1:0]             cur_minutes,
  input  logic [MIN_W-1:0]             cur_seconds,
  output logic [NUM_ALARMS*HOUR_W-1:0] o_hours,
  output logic [NUM_ALARMS*MIN_W-1:0]  o_minutes,
  output logic [NUM_ALARMS-1:0]        o_enable,
  output logic [IDX_W-1:0]             o_sel,
  output logic [2:0]                   o_field,
  output logic                         ack_flag,
  output logic [NUM_ALARMS-1:0]        ring
);

  if (NUM_ALARMS < 2 || !(HOUR_MOD == 12 || HOUR_MOD == 24) || SNOOZE_MIN < 1 || SNOOZE_MIN > 59)
  begin : g_bad_cfg
    $error("multi_alarm_set: parameter out of range");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic             inc_ok, dec_ok, wr_ok;
  logic             snz_take;
  logic [NUM_ALARMS-1:0] snz_fire;

  // mode has priority; inc xor dec is the only combination that writes anything
  assign inc_ok = set_alarm_en & ~mode_button & inc_button;
  assign dec_ok = set_alarm_en & ~mode_button & dec_button;
  assign wr_ok  = inc_ok ^ dec_ok;

  // Editor state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: dropping the grant returns to IDLE from anywhere without an ack
  always_comb begin
    state_d = state_q;
    if (!set_alarm_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_SEL;
        ST_SEL:     if (mode_button) state_d = ST_HOURS;
        ST_HOURS:   if (mode_button) state_d = ST_MINUTES;
        ST_MINUTES: if (mode_button) state_d = ST_ENABLE;
        ST_ENABLE:  if (mode_button) state_d = ST_DONE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  assign o_field  = state_q;
  assign ack_flag = (state_q == ST_DONE);

  mod_updown #(.N(NUM_ALARMS), .W(IDX_W)) u_sel (
    .val_i (sel_q),
    .inc_i (inc_ok && state_q == ST_SEL),
    .dec_i (dec_ok && state_q == ST_SEL),
    .val_o (sel_d)
  );

  // Slot selector register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_q <= '0;
    else     sel_q <= sel_d;
  end

  assign o_sel = sel_q;

  for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_slot
    logic [HOUR_W-1:0] hours_q, hours_d;
    logic [MIN_W-1:0]  min_q, min_d;
    logic              en_q, en_d, ring_q, ring_d;
    logic              hit, wr_h, wr_m, wr_e, match;

    assign hit   = wr_ok && (sel_q == IDX_W'(gi));
    assign wr_h  = hit && (state_q == ST_HOURS);
    assign wr_m  = hit && (state_q == ST_MINUTES);
    assign wr_e  = hit && (state_q == ST_ENABLE);
    assign match = en_q && (cur_hours == hours_q) && (cur_minutes == min_q) && (cur_seconds == '0);

    mod_updown #(.N(HOUR_MOD), .W(HOUR_W)) u_hours (
      .val_i (hours_q), .inc_i (inc_ok & wr_h), .dec_i (dec_ok & wr_h), .val_o (hours_d)
    );

    mod_updown #(.N(MIN_MOD), .W(MIN_W)) u_minutes (
      .val_i (min_q), .inc_i (inc_ok & wr_m), .dec_i (dec_ok & wr_m), .val_o (min_d)
    );

    // Enable and ring next values: an edit of this slot beats a match, a match beats stop
    always_comb begin
      en_d = en_q;
      if (wr_e) en_d = inc_ok;
      ring_d = ring_q;
      if (wr_h || wr_m || wr_e)           ring_d = 1'b0;
      else if (match || snz_fire[gi])     ring_d = 1'b1;
      else if (stop_button || snz_take)   ring_d = 1'b0;
    end

    // Slot registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hours_q <= '0;
        min_q   <= '0;
        en_q    <= 1'b0;
        ring_q  <= 1'b0;
      end else begin
        hours_q <= hours_d;
        min_q   <= min_d;
        en_q    <= en_d;
        ring_q  <= ring_d;
      end
    end

    assign o_hours[gi*HOUR_W +: HOUR_W] = hours_q;
    assign o_minutes[gi*MIN_W +: MIN_W] = min_q;
    assign o_enable[gi]                 = en_q;
    assign ring[gi]                     = ring_q;
  end

`ifdef ALARM_SNOOZE_EN
  logic                  snz_active_q;
  logic [NUM_ALARMS-1:0] snz_mask_q;
  logic [HOUR_W-1:0]     snz_h_q, tgt_h;
  logic [MIN_W-1:0]      snz_m_q, tgt_m;
  logic [MIN_W:0]        min_sum;
  logic                  min_wrap, snz_hit;

  assign min_sum  = {1'b0, cur_minutes} + (MIN_W + 1)'(SNOOZE_MIN);
  assign min_wrap = (min_sum >= (MIN_W + 1)'(MIN_MOD));
  assign tgt_m    = min_wrap ? MIN_W'(min_sum - (MIN_W + 1)'(MIN_MOD)) : min_sum[MIN_W-1:0];

  mod_updown #(.N(HOUR_MOD), .W(HOUR_W)) u_snz_hour (
    .val_i (cur_hours), .inc_i (min_wrap), .dec_i (1'b0), .val_o (tgt_h)
  );

  // stop wins over a simultaneous snooze; snooze with nothing ringing is ignored
  assign snz_take = snooze_button & ~stop_button & (|ring);
  assign snz_hit  = snz_active_q && (cur_hours == snz_h_q) && (cur_minutes == snz_m_q) &&
                    (cur_seconds == '0);
  assign snz_fire = snz_hit ? snz_mask_q : '0;

  // Pending snooze: armed by snooze, cancelled by stop, consumed when the target time arrives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snz_active_q <= 1'b0;
      snz_mask_q   <= '0;
      snz_h_q      <= '0;
      snz_m_q      <= '0;
    end else if (stop_button) begin
      snz_active_q <= 1'b0;
    end else if (snz_take) begin
      snz_active_q <= 1'b1;
      snz_mask_q   <= ring;
      snz_h_q      <= tgt_h;
      snz_m_q      <= tgt_m;
    end else if (snz_hit) begin
      snz_active_q <= 1'b0;
    end
  end
`else
  assign snz_take = 1'b0;
  assign snz_fire = '0;
`endif

endmodule

// File: tb/tb_multi_alarm_set.sv
// tb_multi_alarm_set: vector table plus hand-written sequences for multi_alarm_set (4 slots, 24 h).
module tb_multi_alarm_set;

  localparam int EW = 58;  // {field3, sel2, hours20, minutes24, enable4, ack1, ring4}

  logic        clk = 1'b0;
  logic        rst;
  logic        set_alarm_en, mode_button, inc_button, dec_button, stop_button;
`ifdef ALARM_SNOOZE_EN
  logic        snooze_button = 1'b0;
`endif
  logic [4:0]  cur_hours;
  logic [5:0]  cur_minutes, cur_seconds;
  logic [19:0] o_hours;
  logic [23:0] o_minutes;
  logic [3:0]  o_enable, ring;
  logic [1:0]  o_sel;
  logic [2:0]  o_field;
  logic        ack_flag;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  multi_alarm_set #(.NUM_ALARMS(4), .HOUR_MOD(24), .SNOOZE_MIN(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .set_alarm_en (set_alarm_en),
    .mode_button  (mode_button),
    .inc_button   (inc_button),
    .dec_button   (dec_button),
    .stop_button  (stop_button),
`ifdef ALARM_SNOOZE_EN
    .snooze_button(snooze_button),
`endif
    .cur_hours    (cur_hours),
    .cur_minutes  (cur_minutes),
    .cur_seconds  (cur_seconds),
    .o_hours      (o_hours),
    .o_minutes    (o_minutes),
    .o_enable     (o_enable),
    .o_sel        (o_sel),
    .o_field      (o_field),
    .ack_flag     (ack_flag),
    .ring         (ring)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        en, mode, inc, dec, stop;
    logic [4:0]  h;
    logic [5:0]  m, s;
    int          rep;
    logic [EW-1:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [EW-1:0] pk(input logic [2:0] f, input logic [1:0] sel,
                                       input logic [19:0] hh, input logic [23:0] mm,
                                       input logic [3:0] e, input logic a, input logic [3:0] r);
    return {f, sel, hh, mm, e, a, r};
  endfunction

  function automatic vec_t mk(input logic en, mode, inc, dec, stop, input logic [4:0] h,
                              input logic [5:0] m, s, input int rep, input logic [EW-1:0] exp);
    vec_t v;
    v.en = en; v.mode = mode; v.inc = inc; v.dec = dec; v.stop = stop;
    v.h = h; v.m = m; v.s = s; v.rep = rep; v.exp = exp;
    return v;
  endfunction

  // scoreboard: pop the oldest expectation and compare with the DUT outputs
  task automatic check(input string name);
    logic [EW-1:0] act, e;
    act = {o_field, o_sel, o_hours, o_minutes, o_enable, ack_flag, ring};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no expectation queued, got %h", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", name, act, e);
      end
    end
  endtask

  // driver: hold inputs for rep cycles, compare after the last edge
  task automatic step(input logic en, mode, inc, dec, stop, input logic [4:0] h,
                      input logic [5:0] m, s, input int rep, input logic [EW-1:0] exp,
                      input string name);
    for (int k = 0; k < rep; k++) begin
      set_alarm_en = en; mode_button = mode; inc_button = inc; dec_button = dec;
      stop_button = stop; cur_hours = h; cur_minutes = m; cur_seconds = s;
      if (k == rep - 1) exp_q.push_back(exp);
      @(posedge clk);
      #1;
      if (k == rep - 1) check(name);
    end
    mode_button = 1'b0; inc_button = 1'b0; dec_button = 1'b0; stop_button = 1'b0;
  endtask

`ifdef ALARM_SNOOZE_EN
  task automatic snooze_step(input logic [4:0] h, input logic [5:0] m, s,
                             input logic [EW-1:0] exp, input string name);
    snooze_button = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, h, m, s, 1, exp, name);
    snooze_button = 1'b0;
  endtask
`endif

  localparam logic [19:0] H2   = 20'h01C00;   // slot2 = 7
  localparam logic [23:0] M2   = 24'h01E000;  // slot2 = 30
  localparam logic [19:0] H23  = 20'hB9C00;   // slot3 = 23, slot2 = 7
  localparam logic [23:0] M59  = 24'hEDE000;  // slot3 = 59, slot2 = 30
  localparam logic [19:0] H6   = 20'hB9800;   // slot3 = 23, slot2 = 6

  initial begin
    rst = 1'b1;
    set_alarm_en = 0; mode_button = 0; inc_button = 0; dec_button = 0; stop_button = 0;
    cur_hours = 0; cur_minutes = 0; cur_seconds = 1;
    #2;
    exp_q.push_back(pk(3'd0, 2'd0, 20'h0, 24'h0, 4'h0, 1'b0, 4'h0));
    check("reset_state");
    @(posedge clk);
    #1 rst = 1'b0;

    //            en mode inc dec stop  h  m  s  rep  expected {field,sel,hours,minutes,en,ack,ring}
    tbl.push_back(mk(1, 0, 0, 0, 0,  0,  0, 1,  1, pk(3'd1, 2'd0, 20'h0, 24'h0, 4'h0, 0, 4'h0)));
    tbl.push_back(mk(1, 0, 1, 0, 0,  0,  0, 1,  2, pk(3'd1, 2'd2, 20'h0, 24'h0, 4'h0, 0, 4'h0)));
    tbl.push_back(mk(1, 1, 0, 0, 0,  0,  0, 1,  1, pk(3'd2, 2'd2, 20'h0, 24'h0, 4'h0, 0, 4'h0)));
    tbl.push_back(mk(1, 0, 1, 0, 0,  0,  0, 1,  7, pk(3'd2, 2'd2, H2,    24'h0, 4'h0, 0, 4'h0)));
    tbl.push_back(mk(1, 1, 0, 0, 0,  0,  0, 1,  1, pk(3'd3, 2'd2, H2,    24'h0, 4'h0, 0, 4'h0)));
    tbl.push_back(mk(1, 0, 1, 0, 0,  0,  0, 1, 30, pk(3'd3, 2'd2, H2,    M2,    4'h0, 0, 4'h0)));
    tbl.push_back(mk(1, 1, 0, 0, 0,  0,  0, 1,  1, pk(3'd4, 2'd2, H2,    M2,    4'h0, 0, 4'h0)));
    tbl.push_back(mk(1, 0, 1, 0, 0,  0,  0, 1,  1, pk(3'd4, 2'd2, H2,    M2,    4'h4, 0, 4'h0)));
    tbl.push_back(mk(1, 1, 0, 0, 0,  0,  0, 1,  1, pk(3'd5, 2'd2, H2,    M2,    4'h4, 1, 4'h0)));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0,  0, 1,  1, pk(3'd0, 2'd2, H2,    M2,    4'h4, 0, 4'h0)));
    // ring behaviour
    tbl.push_back(mk(0, 0, 0, 0, 0,  7, 30, 0,  1, pk(3'd0, 2'd2, H2,    M2,    4'h4, 0, 4'h4)));
    tbl.push_back(mk(0, 0, 0, 0, 0,  7, 30, 1,  1, pk(3'd0, 2'd2, H2,    M2,    4'h4, 0, 4'h4)));
    tbl.push_back(mk(0, 0, 0, 0, 1,  7, 30, 1,  1, pk(3'd0, 2'd2, H2,    M2,    4'h4, 0, 4'h0)));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0,  0, 0,  1, pk(3'd0, 2'd2, H2,    M2,    4'h4, 0, 4'h0)));
    tbl.push_back(mk(0, 0, 0, 0, 1,  7, 30, 0,  1, pk(3'd0, 2'd2, H2,    M2,    4'h4, 0, 4'h4)));
    tbl.push_back(mk(0, 0, 0, 0, 1,  0,  0, 1,  1, pk(3'd0, 2'd2, H2,    M2,    4'h4, 0, 4'h0)));
    tbl.push_back(mk(0, 0, 0, 0, 0,  7, 30, 0,  1, pk(3'd0, 2'd2, H2,    M2,    4'h4, 0, 4'h4)));
    // wrap tests on slot 3, ring on slot 2 must survive
    tbl.push_back(mk(1, 0, 0, 0, 0,  0,  0, 1,  1, pk(3'd1, 2'd2, H2,    M2,    4'h4, 0, 4'h4)));
    tbl.push_back(mk(1, 0, 1, 0, 0,  0,  0, 1,  1, pk(3'd1, 2'd3, H2,    M2,    4'h4, 0, 4'h4)));
    tbl.push_back(mk(1, 0, 1, 0, 0,  0,  0, 1,  1, pk(3'd1, 2'd0, H2,    M2,    4'h4, 0, 4'h4)));
    tbl.push_back(mk(1, 0, 0, 1, 0,  0,  0, 1,  1, pk(3'd1, 2'd3, H2,    M2,    4'h4, 0, 4'h4)));
    tbl.push_back(mk(1, 0, 1, 1, 0,  0,  0, 1,  1, pk(3'd1, 2'd3, H2,    M2,    4'h4, 0, 4'h4)));
    tbl.push_back(mk(1, 1, 0, 0, 0,  0,  0, 1,  1, pk(3'd2, 2'd3, H2,    M2,    4'h4, 0, 4'h4)));
    tbl.push_back(mk(1, 0, 0, 1, 0,  0,  0, 1,  1, pk(3'd2, 2'd3, H23,   M2,    4'h4, 0, 4'h4)));
    tbl.push_back(mk(1, 0, 1, 0, 0,  0,  0, 1,  1, pk(3'd2, 2'd3, H2,    M2,    4'h4, 0, 4'h4)));
    tbl.push_back(mk(1, 0, 0, 1, 0,  0,  0, 1,  1, pk(3'd2, 2'd3, H23,   M2,    4'h4, 0, 4'h4)));
    tbl.push_back(mk(1, 0, 1, 1, 0,  0,  0, 1,  1, pk(3'd2, 2'd3, H23,   M2,    4'h4, 0, 4'h4)));
    tbl.push_back(mk(1, 1, 0, 0, 0,  0,  0, 1,  1, pk(3'd3, 2'd3, H23,   M2,    4'h4, 0, 4'h4)));
    tbl.push_back(mk(1, 0, 0, 1, 0,  0,  0, 1,  1, pk(3'd3, 2'd3, H23,   M59,   4'h4, 0, 4'h4)));
    tbl.push_back(mk(1, 0, 1, 0, 0,  0,  0, 1,  1, pk(3'd3, 2'd3, H23,   M2,    4'h4, 0, 4'h4)));
    tbl.push_back(mk(1, 0, 0, 1, 0,  0,  0, 1,  1, pk(3'd3, 2'd3, H23,   M59,   4'h4, 0, 4'h4)));
    // abort from MINUTES: no ack, edits kept
    tbl.push_back(mk(0, 0, 0, 0, 0,  0,  0, 1,  1, pk(3'd0, 2'd3, H23,   M59,   4'h4, 0, 4'h4)));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0,  0, 1,  1, pk(3'd0, 2'd3, H23,   M59,   4'h4, 0, 4'h4)));
    // editing slot 2 clears its ring even against a live match
    tbl.push_back(mk(1, 0, 0, 0, 0,  0,  0, 1,  1, pk(3'd1, 2'd3, H23,   M59,   4'h4, 0, 4'h4)));
    tbl.push_back(mk(1, 0, 0, 1, 0,  0,  0, 1,  1, pk(3'd1, 2'd2, H23,   M59,   4'h4, 0, 4'h4)));
    tbl.push_back(mk(1, 1, 0, 0, 0,  0,  0, 1,  1, pk(3'd2, 2'd2, H23,   M59,   4'h4, 0, 4'h4)));
    tbl.push_back(mk(1, 0, 1, 1, 0,  7, 30, 0,  1, pk(3'd2, 2'd2, H23,   M59,   4'h4, 0, 4'h4)));
    tbl.push_back(mk(1, 0, 0, 1, 0,  7, 30, 0,  1, pk(3'd2, 2'd2, H6,    M59,   4'h4, 0, 4'h0)));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0,  0, 1,  1, pk(3'd0, 2'd2, H6,    M59,   4'h4, 0, 4'h0)));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].en, tbl[i].mode, tbl[i].inc, tbl[i].dec, tbl[i].stop,
           tbl[i].h, tbl[i].m, tbl[i].s, tbl[i].rep, tbl[i].exp, $sformatf("tbl[%0d]", i));
    end

    // asynchronous reset in the middle of a MINUTES edit
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, pk(3'd1, 2'd2, H6, M59, 4'h4, 0, 4'h0), "rst_pre_sel");
    step(1, 1, 0, 0, 0, 0, 0, 1, 1, pk(3'd2, 2'd2, H6, M59, 4'h4, 0, 4'h0), "rst_pre_hours");
    step(1, 1, 0, 0, 0, 0, 0, 1, 1, pk(3'd3, 2'd2, H6, M59, 4'h4, 0, 4'h0), "rst_pre_minutes");
    rst = 1'b1;
    #1;
    exp_q.push_back(pk(3'd0, 2'd0, 20'h0, 24'h0, 4'h0, 1'b0, 4'h0));
    check("rst_async");
    set_alarm_en = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;

    // slot 0 at 00:00: a ring cannot come from a slot written in the same cycle
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, pk(3'd1, 2'd0, 20'h0, 24'h0, 4'h0, 0, 4'h0), "s0_sel");
    step(1, 1, 0, 0, 0, 0, 0, 1, 3, pk(3'd4, 2'd0, 20'h0, 24'h0, 4'h0, 0, 4'h0), "s0_to_enable");
    step(1, 0, 1, 0, 0, 0, 0, 0, 1, pk(3'd4, 2'd0, 20'h0, 24'h0, 4'h1, 0, 4'h0), "s0_enable_write");
    step(1, 0, 1, 0, 0, 0, 0, 0, 1, pk(3'd4, 2'd0, 20'h0, 24'h0, 4'h1, 0, 4'h0), "s0_edit_wins");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, pk(3'd0, 2'd0, 20'h0, 24'h0, 4'h1, 0, 4'h1), "s0_ring");
    step(0, 0, 0, 0, 1, 0, 0, 1, 1, pk(3'd0, 2'd0, 20'h0, 24'h0, 4'h1, 0, 4'h0), "s0_stop");

`ifdef ALARM_SNOOZE_EN
    // slot 2 to 23:58 using only dec, then exercise snooze
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, pk(3'd1, 2'd0, 20'h0,    24'h0,   4'h1, 0, 4'h0), "sz_sel");
    step(1, 0, 0, 1, 0, 0, 0, 1, 2, pk(3'd1, 2'd2, 20'h0,    24'h0,   4'h1, 0, 4'h0), "sz_sel2");
    step(1, 1, 0, 0, 0, 0, 0, 1, 1, pk(3'd2, 2'd2, 20'h0,    24'h0,   4'h1, 0, 4'h0), "sz_hours");
    step(1, 0, 0, 1, 0, 0, 0, 1, 1, pk(3'd2, 2'd2, 20'h5C00, 24'h0,   4'h1, 0, 4'h0), "sz_h23");
    step(1, 1, 0, 0, 0, 0, 0, 1, 1, pk(3'd3, 2'd2, 20'h5C00, 24'h0,   4'h1, 0, 4'h0), "sz_minutes");
    step(1, 0, 0, 1, 0, 0, 0, 1, 2, pk(3'd3, 2'd2, 20'h5C00, 24'h3A000, 4'h1, 0, 4'h0), "sz_m58");
    step(1, 1, 0, 0, 0, 0, 0, 1, 1, pk(3'd4, 2'd2, 20'h5C00, 24'h3A000, 4'h1, 0, 4'h0), "sz_enable");
    step(1, 0, 1, 0, 0, 0, 0, 1, 1, pk(3'd4, 2'd2, 20'h5C00, 24'h3A000, 4'h5, 0, 4'h0), "sz_en_set");
    step(1, 1, 0, 0, 0, 0, 0, 1, 1, pk(3'd5, 2'd2, 20'h5C00, 24'h3A000, 4'h5, 1, 4'h0), "sz_done");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, pk(3'd0, 2'd2, 20'h5C00, 24'h3A000, 4'h5, 0, 4'h0), "sz_idle");
    step(0, 0, 0, 0, 0, 23, 58, 0, 1, pk(3'd0, 2'd2, 20'h5C00, 24'h3A000, 4'h5, 0, 4'h4), "sz_ring");
    snooze_step(23, 58, 1, pk(3'd0, 2'd2, 20'h5C00, 24'h3A000, 4'h5, 0, 4'h0), "sz_snooze");
    step(0, 0, 0, 0, 0, 0, 2, 0, 1, pk(3'd0, 2'd2, 20'h5C00, 24'h3A000, 4'h5, 0, 4'h0), "sz_early");
    step(0, 0, 0, 0, 0, 0, 3, 0, 1, pk(3'd0, 2'd2, 20'h5C00, 24'h3A000, 4'h5, 0, 4'h4), "sz_rering");
    step(0, 0, 0, 0, 1, 0, 3, 1, 1, pk(3'd0, 2'd2, 20'h5C00, 24'h3A000, 4'h5, 0, 4'h0), "sz_stop1");
    step(0, 0, 0, 0, 0, 23, 58, 0, 1, pk(3'd0, 2'd2, 20'h5C00, 24'h3A000, 4'h5, 0, 4'h4), "sz_ring2");
    snooze_step(23, 58, 1, pk(3'd0, 2'd2, 20'h5C00, 24'h3A000, 4'h5, 0, 4'h0), "sz_snooze2");
    step(0, 0, 0, 0, 1, 23, 59, 1, 1, pk(3'd0, 2'd2, 20'h5C00, 24'h3A000, 4'h5, 0, 4'h0), "sz_cancel");
    step(0, 0, 0, 0, 0, 0, 3, 0, 1, pk(3'd0, 2'd2, 20'h5C00, 24'h3A000, 4'h5, 0, 4'h0), "sz_no_rering");
    snooze_step(0, 3, 1, pk(3'd0, 2'd2, 20'h5C00, 24'h3A000, 4'h5, 0, 4'h0), "sz_idle_snooze");
    step(0, 0, 0, 0, 0, 0, 8, 0, 1, pk(3'd0, 2'd2, 20'h5C00, 24'h3A000, 4'h5, 0, 4'h0), "sz_ignored");
`endif

    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_alarm_set.md
# multi_alarm_set

Parametrised alarm-bank editor and matcher for the digital clock. It holds NUM_ALARMS independent alarm slots, each with hours, minutes and an enable bit. Slots are edited through the shared mode/inc/dec buttons. Edited values wrap correctly in both directions. Each enabled slot is compared against the running time from the timekeeping block, and a per-slot ring flag is raised on a match. The block sits beside the time-setting logic and is granted the buttons while `set_alarm_en` is high.

## Interface
Parameters:
- NUM_ALARMS, 4, number of alarm slots (≥2); IDX_W = $clog2(NUM_ALARMS) is a derived localparam
- HOUR_MOD, 24, hour modulus (12 or 24)
- SNOOZE_MIN, 5, snooze offset in minutes (1..59); only used with ALARM_SNOOZE_EN

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- set_alarm_en  in  1  editor grant (level)
- mode_button  in  1  advance field (single-cycle pulse, debounced upstream)
- inc_button  in  1  increment current field (pulse)
- dec_button  in  1  decrement current field (pulse)
- stop_button  in  1  clear all ring flags (pulse)
- snooze_button  in  1  only present with ALARM_SNOOZE_EN
- cur_hours  in  5  running hours
- cur_minutes  in  6  running minutes
- cur_seconds  in  6  running seconds
- o_hours  out  NUM_ALARMS*5  slot i in bits [5i+4:5i]
- o_minutes  out  NUM_ALARMS*6  slot i in bits [6i+5:6i]
- o_enable  out  NUM_ALARMS  per-slot armed bit
- o_sel  out  IDX_W  slot under edit
- o_field  out  3  current FSM state encoding, for display blinking
- ack_flag  out  1  one-cycle pulse when an edit pass completes
- ring  out  NUM_ALARMS  per-slot ring flag

## Operation
- FSM states: IDLE, SEL, HOURS, MINUTES, ENABLE, DONE.
  - IDLE→SEL when set_alarm_en=1.
  - mode_button advances SEL→HOURS→MINUTES→ENABLE→DONE.
  - DONE→IDLE unconditionally after one cycle.
- set_alarm_en=0 in any state → IDLE on the next cycle. No ack is issued. Values already written are kept.
- Button priority within a cycle: mode > (inc xor dec). inc and dec together → no change.
- Edit actions by state:
  - SEL: o_sel ±1 mod NUM_ALARMS.
  - HOURS: slot hours ±1 mod HOUR_MOD.
  - MINUTES: slot minutes ±1 mod 60.
  - ENABLE: inc sets the enable bit, dec clears it.
- Any hours, minutes or enable write to slot i clears ring[i].
- Match: the compare is performed each cycle.
  - Slot i matches when o_enable[i]=1, cur_hours=hours[i], cur_minutes=minutes[i] and cur_seconds=0.
  - A match sets ring[i]. ring[i] holds until stop_button or an edit of slot i.
- A match in the same cycle as stop_button: the match wins.
- Rings fire in every state, including while editing. They do not fire from a slot being edited in the same cycle (that slot's edit clear wins).

## Timing
- Reset values: o_hours=0, o_minutes=0, o_enable=0, o_sel=0, state IDLE (o_field=0), ack_flag=0, ring=0, snooze state cleared.
- Latency: every button effect is visible on its output one cycle after the pulse.
- ring[i] rises one cycle after the matching cur_* values.
- ack_flag is high for exactly the cycle the FSM is in DONE, which is the cycle after the mode pulse in ENABLE.
- Held buttons act once per cycle; no auto-repeat logic.
- rst mid-edit aborts immediately; all slot contents are lost.

## Configuration
- ALARM_SNOOZE_EN defined:
  - snooze_button exists.
  - While ring≠0, snooze_button clears ring and stores snz_mask=ring.
  - It also stores a target equal to the current time + SNOOZE_MIN minutes, wrapping minutes at 60 and hours at HOUR_MOD, and sets snz_active.
  - When the target matches with cur_seconds=0, ring |= snz_mask and snz_active clears.
  - stop_button cancels a pending snooze.
  - Snooze with ring=0 is ignored.
- ALARM_SNOOZE_EN undefined: no snooze port, no snooze registers; stop_button is the only ring clear.

## Structure
- Shared package alarm_pkg holds:
  - state enum and o_field encoding;
  - HOUR_W=5, MIN_W=6, MIN_MOD=60.
- Sub-module mod_updown is a combinational modulo-N ±1 helper with parameters N and W. It is reused for o_sel, hours, minutes and the snooze add.
- The slot register array and match compare are generated per slot in the top module.

## Test plan
- Reset: assert rst during MINUTES edit → all outputs 0 and o_field=IDLE without a clock edge.
- Program slot 2 to 07:30 enabled:
  - Stimulus: set_alarm_en=1; inc×2; mode; inc×7; mode; inc×30; mode; inc; mode.
  - Expected: ack_flag high for 1 cycle; o_hours[14:10]=7; o_minutes[17:12]=30; o_enable=4'b0100.
- Wrap:
  - Hours: 23 inc→0, then dec→23.
  - Minutes: 59 inc→0, 0 dec→59.
  - o_sel: 3 inc→0.
  - inc+dec together → no change.
- Ring:
  - Slot 2 07:30 enabled, drive 07:30:00 → ring=4'b0100 next cycle; 07:30:01 keeps it.
  - stop_button → ring=0.
  - Same time on a disabled slot → no ring.
  - stop_button coincident with match → ring set.
- Abort: drop set_alarm_en in MINUTES → IDLE next cycle, ack_flag never high, partial edits retained.
- Snooze (ALARM_SNOOZE_EN, SNOOZE_MIN=5): ring at 23:58:00, snooze_button → ring=0; at 00:03:00 ring=4'b0100 again; with stop_button instead of waiting → no re-ring.
